btn_debounce: RTL
=================

# btn_debounce

Multi-channel push-button conditioner for the gomoku board front end: synchronizes raw FPGA button inputs (cursor up/down/left/right, place), rejects contact bounce, and emits clean one-cycle press pulses with optional auto-repeat while a key is held. It sits directly upstream of the pulse-delay stage and the cursor/placement control logic. Each `key_pulse` bit is a legal single-cycle trigger for a downstream one-shot delay.

## Interface
- `NUM_KEYS`, default 5: number of independent button channels.
- `DEBOUNCE_CNT`, default 26'd1_000_000: stable cycles required to accept a press or a release (10 ms at 100 MHz). Must be ≥ 1.
- `REPEAT_DLY`, default 26'd50_000_000: held cycles before the first auto-repeat pulse. 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 26'd10_000_000: cycles between subsequent repeat pulses. Must be ≥ 1 when `REPEAT_DLY` ≠ 0.
- `CLK`, input, 1: system clock.
- `RST`, input, 1: reset, synchronous, active-low.
- `key_in`, input, NUM_KEYS: raw asynchronous buttons, active-high.
- `key_level`, output, NUM_KEYS: debounced key state, 1 = held.
- `key_pulse`, output, NUM_KEYS: one-cycle pulse on accepted press and on each auto-repeat.
- `any_pulse`, output, 1: OR of `key_pulse`, same cycle.

## Operation
- Per channel: 2-flop synchronizer (`s1`, `s2`) → FSM plus one 26-bit counter and one 26-bit repeat counter. Channels are fully independent.
- States: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
- IDLE: count=0. `s2`=1 → WAIT_PRESS, count=0.
- WAIT_PRESS: `s2`=0 → IDLE (bounce rejected, no pulse). count==DEBOUNCE_CNT-1 → PRESSED, set `key_level`, assert `key_pulse` for one cycle, repeat counter=0, phase=first. Otherwise count+1.
- PRESSED: `s2`=0 → WAIT_RELEASE, count=0. Else if `REPEAT_DLY`≠0, increment the repeat counter. On reaching the phase limit (phase first: REPEAT_DLY-1; phase periodic: REPEAT_PERIOD-1), pulse, clear the counter and set phase=periodic.
- WAIT_RELEASE: `key_level` stays 1; no repeat pulses. `s2`=1 → PRESSED, repeat counter=0, phase=first, no pulse. count==DEBOUNCE_CNT-1 → IDLE and clear `key_level`.
- Undefined state encoding → IDLE.
- Counters are fixed at 26 bits. Parameter values above 2^26-1 are illegal. Counters never wrap, because each is cleared on its terminal value.

## Timing
- Reset: while `RST`=0 at an edge, every state→IDLE, counters, synchronizers, `key_level`, `key_pulse` and `any_pulse` → 0. This applies to reset asserted mid-operation in any state. The first post-reset press needs full synchronizer plus debounce latency.
- All outputs are registered except `any_pulse`, which is combinational from registered `key_pulse`.
- Edge 0 is the first edge sampling `key_in`=1, with the input stable thereafter. WAIT_PRESS is entered at edge 2. `key_pulse` and `key_level` rise after edge DEBOUNCE_CNT+2. The pulse lasts exactly 1 cycle.
- First repeat pulse follows edge DEBOUNCE_CNT+2+REPEAT_DLY. Each later repeat pulse follows by REPEAT_PERIOD cycles.
- Edge R is the first edge sampling `key_in`=0, stable thereafter. WAIT_RELEASE is entered at edge R+2. `key_level` falls after edge R+DEBOUNCE_CNT+2.
- Simultaneous presses on several channels produce simultaneous `key_pulse` bits. `any_pulse` is 1 for that single cycle.

## Structure
- Shared package/header holds the state encodings (IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_RELEASE=2'd3) and `CNT_W`=26.
- Sub-module `btn_debounce_ch` holds one synchronizer, FSM and counter pair. The top instantiates `NUM_KEYS` copies via generate and ORs the pulses.

## Test plan
Bench parameters: DEBOUNCE_CNT=4, REPEAT_DLY=20, REPEAT_PERIOD=8, NUM_KEYS=5.

- **Clean press/release:** `key_in[0]` high from edge 0, held 15 cycles, then low from edge R. Required: `key_pulse[0]` high only after edge 6. `key_level[0]` rises after edge 6 and falls after edge R+6.
- **Bounce rejection:** `key_in[1]` toggles 1-1-0-1-0 before going stable high. Required: no pulse during bouncing. Exactly one pulse, 6 cycles after the last rising sample.
- **Auto-repeat:** `key_in[2]` held 50 cycles from edge 0. Required: pulses after edges 6, 26, 34, 42, 50, and none other while held.
- **Release glitch:** `key_in[2]` held, then low for 2 samples, then high again. Required: `key_level` stays 1, no extra press pulse, and the repeat timer restarts (next pulse 20 cycles after re-entering PRESSED).
- **Simultaneous keys:** `key_in[3]` and `key_in[4]` rise on the same edge. Required: both `key_pulse` bits and `any_pulse` high in the same single cycle.
- **Mid-operation reset:** `RST` driven low while a key is in PRESSED. Required: all outputs 0 after that edge. With the key still held after reset release, a new pulse follows DEBOUNCE_CNT+2 edges later.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioner: counter width,
// per-channel FSM state encoding and auto-repeat phase.
package btn_debounce_pkg;

  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } key_state_t;

  typedef enum logic {
    PHASE_FIRST    = 1'b0,
    PHASE_PERIODIC = 1'b1
  } rep_phase_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between the raw board inputs and the conditioned outputs.
// The slave side is the conditioner; the master side drives the raw keys.
interface btn_debounce_if #(
  parameter int NUM_KEYS = 5
);

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_pulse;
  logic                any_pulse;

  modport master (
    output key_in,
    input  key_level,
    input  key_pulse,
    input  any_pulse
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_pulse,
    output any_pulse
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, and auto-repeat
// timer producing a debounced level and single-cycle press/repeat pulses.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_CNT  = 26'd1_000_000,
  parameter logic [CNT_W-1:0] REPEAT_DLY    = 26'd50_000_000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD = 26'd10_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST  = DEBOUNCE_CNT - CNT_ONE;
  localparam logic [CNT_W-1:0] DLY_LAST  = REPEAT_DLY - CNT_ONE;
  localparam logic [CNT_W-1:0] PER_LAST  = REPEAT_PERIOD - CNT_ONE;
  localparam bit               REPEAT_ON = (REPEAT_DLY != '0);

  logic             s1;
  logic             s2;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] rep;
  logic [CNT_W-1:0] rep_nxt;
  logic [CNT_W-1:0] rep_last;
  rep_phase_t       phase;
  rep_phase_t       phase_nxt;
  logic             level_nxt;
  logic             pulse_nxt;

  assign rep_last = (phase == PHASE_FIRST) ? DLY_LAST : PER_LAST;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE;
      count <= '0;
      rep   <= '0;
      phase <= PHASE_FIRST;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= key_raw;
      s2    <= s1;
      state <= state_nxt;
      count <= count_nxt;
      rep   <= rep_nxt;
      phase <= phase_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

  // A short dip while held re-enters PRESSED silently and restarts the repeat delay.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    rep_nxt   = rep;
    phase_nxt = phase;
    level_nxt = level;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        count_nxt = '0;
        level_nxt = 1'b0;
        if (s2) begin
          state_nxt = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!s2) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (count == DEB_LAST) begin
          state_nxt = PRESSED;
          count_nxt = '0;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
          rep_nxt   = '0;
          phase_nxt = PHASE_FIRST;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_nxt = WAIT_RELEASE;
          count_nxt = '0;
        end else if (REPEAT_ON) begin
          if (rep == rep_last) begin
            pulse_nxt = 1'b1;
            rep_nxt   = '0;
            phase_nxt = PHASE_PERIODIC;
          end else begin
            rep_nxt = rep + CNT_ONE;
          end
        end
      end
      WAIT_RELEASE: begin
        if (s2) begin
          state_nxt = PRESSED;
          count_nxt = '0;
          rep_nxt   = '0;
          phase_nxt = PHASE_FIRST;
        end else if (count == DEB_LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
          level_nxt = 1'b0;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        rep_nxt   = '0;
        phase_nxt = PHASE_FIRST;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: one independent debounce channel
// per key, with the press/repeat pulses also merged into any_pulse.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int               NUM_KEYS      = 5,
  parameter logic [CNT_W-1:0] DEBOUNCE_CNT  = 26'd1_000_000,
  parameter logic [CNT_W-1:0] REPEAT_DLY    = 26'd50_000_000,
  parameter logic [CNT_W-1:0] REPEAT_PERIOD = 26'd10_000_000
) (
  input  logic            CLK,
  input  logic            RST,
  btn_debounce_if.slave   bus
);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] pulse;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CNT  (DEBOUNCE_CNT),
      .REPEAT_DLY    (REPEAT_DLY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .key_raw (bus.key_in[i]),
      .level   (level[i]),
      .pulse   (pulse[i])
    );
  end

  // any_pulse is combinational from the registered pulses, so it aligns exactly.
  assign bus.key_level = level;
  assign bus.key_pulse = pulse;
  assign bus.any_pulse = |pulse;

endmodule
